// File: rtl/lfsr6_checker.sv
// Self-test monitor for the 6-bit Galois LFSR generator: tracks the stream,
// acquires and loses lock, and keeps a saturating count of locked mismatches.
module lfsr6_checker #(
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 3,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    input  logic [5:0]       in_data,
    input  logic             clr_cnt,
    output logic             lock,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_N_C = 4'(LOCK_N);
    localparam logic [3:0]       LOSS_N_C = 4'(LOSS_N);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    // One generator step: bit 5 shifts out and feeds back into bits 0 and 3.
    function automatic logic [5:0] step(input logic [5:0] s);
        return {s[4], s[3], s[2] ^ s[5], s[1], s[0], s[5]};
    endfunction

    state_t           state_r, state_nxt_s;
    logic [5:0]       exp_r, exp_nxt_s;
    logic [3:0]       match_cnt_r, match_nxt_s;
    logic [3:0]       miss_cnt_r, miss_nxt_s;
    logic             lock_r, err_pulse_r;
    logic [ERR_W-1:0] err_cnt_r, err_cnt_nxt_s;
    logic             pulse_nxt_s;
    logic             err_inc_s;

    // Next-state, expected-word and counter updates for one valid word.
    always_comb begin
        state_nxt_s = state_r;
        exp_nxt_s   = exp_r;
        match_nxt_s = match_cnt_r;
        miss_nxt_s  = miss_cnt_r;
        pulse_nxt_s = 1'b0;
        err_inc_s   = 1'b0;
        if (in_valid) begin
            case (state_r)
                SEARCH: begin
                    if (in_data != 6'h00) begin
                        exp_nxt_s   = step(in_data);
                        match_nxt_s = 4'd0;
                        state_nxt_s = VERIFY;
                    end else begin
                        state_nxt_s = SEARCH;
                    end
                end
                VERIFY: begin
                    if (in_data == exp_r) begin
                        exp_nxt_s   = step(in_data);
                        match_nxt_s = match_cnt_r + 4'd1;
                        if ((match_cnt_r + 4'd1) == LOCK_N_C) begin
                            state_nxt_s = LOCKED;
                            miss_nxt_s  = 4'd0;
                        end else begin
                            state_nxt_s = VERIFY;
                        end
                    end else if (in_data == 6'h00) begin
                        match_nxt_s = 4'd0;
                        state_nxt_s = SEARCH;
                    end else begin
                        exp_nxt_s   = step(in_data);
                        match_nxt_s = 4'd0;
                    end
                end
                LOCKED: begin
                    // Once locked the prediction free-runs so a corrupt word cannot reseed it.
                    exp_nxt_s = step(exp_r);
                    if (in_data == exp_r) begin
                        miss_nxt_s = 4'd0;
                    end else begin
                        pulse_nxt_s = 1'b1;
                        err_inc_s   = 1'b1;
                        miss_nxt_s  = miss_cnt_r + 4'd1;
                        if ((miss_cnt_r + 4'd1) == LOSS_N_C) begin
                            state_nxt_s = SEARCH;
                            miss_nxt_s  = 4'd0;
                        end else begin
                            state_nxt_s = LOCKED;
                        end
                    end
                end
                default: begin
                    state_nxt_s = SEARCH;
                    match_nxt_s = 4'd0;
                    miss_nxt_s  = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Saturating error count; a clear beats a simultaneous increment.
    always_comb begin
        err_cnt_nxt_s = err_cnt_r;
        if (clr_cnt) begin
            err_cnt_nxt_s = {ERR_W{1'b0}};
        end else if (err_inc_s && (err_cnt_r != ERR_MAX)) begin
            err_cnt_nxt_s = err_cnt_r + ERR_ONE;
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r     <= SEARCH;
            exp_r       <= 6'h00;
            match_cnt_r <= 4'd0;
            miss_cnt_r  <= 4'd0;
            lock_r      <= 1'b0;
            err_pulse_r <= 1'b0;
            err_cnt_r   <= {ERR_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            exp_r       <= exp_nxt_s;
            match_cnt_r <= match_nxt_s;
            miss_cnt_r  <= miss_nxt_s;
            lock_r      <= (state_nxt_s == LOCKED);
            err_pulse_r <= pulse_nxt_s;
            err_cnt_r   <= err_cnt_nxt_s;
        end
    end

    assign lock      = lock_r;
    assign err_pulse = err_pulse_r;
    assign err_cnt   = err_cnt_r;
    assign state     = state_r;

endmodule

// File: tb/tb_lfsr6_checker.sv
// Bench for lfsr6_checker: an 8-bit counter instance and a 2-bit counter
// instance share one stimulus stream; expectations go through a queue.
module tb_lfsr6_checker;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       in_valid;
    logic [5:0] in_data;
    logic       clr_cnt;

    logic       lock_a, pulse_a, lock_b, pulse_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b, st_a, st_b;

    always #5 clk = ~clk;

    lfsr6_checker #(.LOCK_N(4), .LOSS_N(3), .ERR_W(8)) dut_a (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_data(in_data),
        .clr_cnt(clr_cnt), .lock(lock_a), .err_pulse(pulse_a),
        .err_cnt(cnt_a), .state(st_a)
    );

    lfsr6_checker #(.LOCK_N(4), .LOSS_N(3), .ERR_W(2)) dut_b (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_data(in_data),
        .clr_cnt(clr_cnt), .lock(lock_b), .err_pulse(pulse_b),
        .err_cnt(cnt_b), .state(st_b)
    );

    typedef struct {
        logic       v;
        logic [5:0] d;
        logic       c;
        logic [1:0] st;
        logic       lk;
        logic       pl;
        logic [7:0] cnt;
    } vec_t;

    vec_t       sbq[$];
    vec_t       tbl[12];
    int         checks = 0;
    int         passed = 0;
    logic [5:0] g;

    function automatic logic [5:0] step(input logic [5:0] s);
        logic [5:0] n;
        n[0] = s[5];
        n[1] = s[0];
        n[2] = s[1];
        n[3] = s[2] ^ s[5];
        n[4] = s[3];
        n[5] = s[4];
        return n;
    endfunction

    function automatic vec_t mk(input logic v, input logic [5:0] d, input logic c,
                                input logic [1:0] st, input logic lk, input logic pl,
                                input logic [7:0] cnt);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.st = st; r.lk = lk; r.pl = pl; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic check_outs(input vec_t e);
        int sat;
        sat = (e.cnt > 8'd3) ? 3 : int'(e.cnt);
        chk("state_a", int'(st_a), int'(e.st));
        chk("lock_a", int'(lock_a), int'(e.lk));
        chk("pulse_a", int'(pulse_a), int'(e.pl));
        chk("cnt_a", int'(cnt_a), int'(e.cnt));
        chk("state_b", int'(st_b), int'(e.st));
        chk("lock_b", int'(lock_b), int'(e.lk));
        chk("pulse_b", int'(pulse_b), int'(e.pl));
        chk("cnt_b", int'(cnt_b), sat);
    endtask

    task automatic cyc(input vec_t e);
        vec_t got;
        in_valid = e.v;
        in_data  = e.d;
        clr_cnt  = e.c;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sbq.pop_front();
        check_outs(got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0; in_valid = 1'b0; in_data = 6'h00; clr_cnt = 1'b0;
        // Zeros and idle gaps in SEARCH, then acquisition on the reset sequence.
        tbl[0]  = mk(1'b1, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
        tbl[1]  = mk(1'b0, 6'h3F, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
        tbl[2]  = mk(1'b1, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
        tbl[3]  = mk(1'b0, 6'h15, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
        tbl[4]  = mk(1'b1, 6'h3F, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0);
        tbl[5]  = mk(1'b0, 6'h00, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0);
        tbl[6]  = mk(1'b1, 6'h37, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0);
        tbl[7]  = mk(1'b0, 6'h2A, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0);
        tbl[8]  = mk(1'b1, 6'h27, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0);
        tbl[9]  = mk(1'b1, 6'h07, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0);
        tbl[10] = mk(1'b1, 6'h0E, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0);
        tbl[11] = mk(1'b1, 6'h1C, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0);

        @(negedge clk);
        check_outs(mk(1'b0, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0));
        rst_b = 1'b1;

        for (int i = 0; i < 12; i++) cyc(tbl[i]);
        g = step(6'h1C);

        // Clean locked stream.
        for (int i = 0; i < 100; i++) begin
            cyc(mk(1'b1, g, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0));
            g = step(g);
        end
        for (int i = 0; i < 12 && g != 6'h07; i++) begin
            cyc(mk(1'b1, g, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0));
            g = step(g);
        end

        // Single corrupt word: 00 in place of 07, then 0E must still match.
        cyc(mk(1'b1, 6'h00, 1'b0, 2'd2, 1'b1, 1'b1, 8'd1));
        g = step(g);
        cyc(mk(1'b1, g, 1'b0, 2'd2, 1'b1, 1'b0, 8'd1));
        g = step(g);
        cyc(mk(1'b0, 6'h00, 1'b1, 2'd2, 1'b1, 1'b0, 8'd0));

        // Three consecutive misses drop lock on the third.
        for (int k = 1; k <= 3; k++) begin
            cyc(mk(1'b1, g ^ 6'h01, 1'b0, (k == 3) ? 2'd0 : 2'd2,
                   (k == 3) ? 1'b0 : 1'b1, 1'b1, 8'(k)));
            g = step(g);
        end

        // Reacquire, with a zero and a reseed in VERIFY along the way.
        cyc(mk(1'b1, g, 1'b0, 2'd1, 1'b0, 1'b0, 8'd3));
        g = step(g);
        cyc(mk(1'b1, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'd3));
        cyc(mk(1'b1, g, 1'b0, 2'd1, 1'b0, 1'b0, 8'd3));
        g = step(g);
        cyc(mk(1'b1, g ^ 6'h01, 1'b0, 2'd1, 1'b0, 1'b0, 8'd3));
        g = step(g);
        cyc(mk(1'b1, g, 1'b0, 2'd1, 1'b0, 1'b0, 8'd3));
        g = step(g);
        for (int k = 1; k <= 4; k++) begin
            cyc(mk(1'b1, g, 1'b0, (k == 4) ? 2'd2 : 2'd1, (k == 4), 1'b0, 8'd3));
            g = step(g);
        end

        // Alternating bad/good: the 2-bit counter saturates at 3.
        cyc(mk(1'b0, 6'h00, 1'b1, 2'd2, 1'b1, 1'b0, 8'd0));
        for (int k = 1; k <= 5; k++) begin
            cyc(mk(1'b1, g ^ 6'h20, 1'b0, 2'd2, 1'b1, 1'b1, 8'(k)));
            g = step(g);
            cyc(mk(1'b1, g, 1'b0, 2'd2, 1'b1, 1'b0, 8'(k)));
            g = step(g);
        end
        cyc(mk(1'b1, g ^ 6'h01, 1'b0, 2'd2, 1'b1, 1'b1, 8'd6));
        g = step(g);
        cyc(mk(1'b1, g ^ 6'h01, 1'b1, 2'd2, 1'b1, 1'b1, 8'd0));
        g = step(g);
        cyc(mk(1'b1, g, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0));
        g = step(g);

        // Asynchronous reset between edges while locked.
        cyc(mk(1'b1, g ^ 6'h01, 1'b0, 2'd2, 1'b1, 1'b1, 8'd1));
        g = step(g);
        #2;
        rst_b = 1'b0;
        #1;
        check_outs(mk(1'b0, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0));
        @(negedge clk);
        rst_b = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(mk(1'b1, g, 1'b0, (k == 5) ? 2'd2 : 2'd1, (k == 5), 1'b0, 8'd0));
            g = step(g);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
